// File: rtl/ntt_ctrl.sv
// ntt_ctrl -- butterfly issue sequencer for an in-place forward NTT
// (Cooley-Tukey, twiddles stored in bit-reversed psi order).
//
// Each accepted cycle issues one butterfly: the two coefficient addresses
// and the twiddle index for psi_table.  Between stages the issue stream
// pauses for BF_LATENCY cycles, so stage s+1 never reads a coefficient that
// the datapath has not yet written back.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request a full transform; honoured only in IDLE
//   busy      out  1      high from the cycle after accepted start through DONE
//   done      out  1      one-cycle pulse once the final stage has drained
//   bf_valid  out  1      butterfly issue valid
//   bf_ready  in   1      datapath accepts the issue (transfer = valid & ready)
//   addr_a    out  LOG_N  upper butterfly coefficient index j
//   addr_b    out  LOG_N  lower butterfly coefficient index j+t
//   psi_addr  out  LOG_N  twiddle index (1<<s)+i
//   stage     out  3      current stage s
//
// All outputs are registered from the next-state values, so no input
// reaches an output through combinational logic alone.
module ntt_ctrl #(
  parameter int LOG_N      = 5,
  parameter int BF_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOG_N-1:0] addr_a,
  output logic [LOG_N-1:0] addr_b,
  output logic [LOG_N-1:0] psi_addr,
  output logic [2:0]       stage
);

  localparam int KW    = LOG_N - 1;
  localparam int CNT_W = (BF_LATENCY > 0) ? $clog2(BF_LATENCY + 1) : 1;

  localparam logic [KW-1:0]    K_LAST  = {KW{1'b1}};
  localparam logic [KW-1:0]    K_ONE   = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [2:0]       S_LAST  = 3'(LOG_N - 1);
  localparam logic [LOG_N-1:0] ONE_N   = {{(LOG_N-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(BF_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [2:0]           s_r, s_s;
  logic [KW-1:0]        k_r, k_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic                 xfer_s;
  logic [3*LOG_N-1:0]   addr_vec_s;

  // Butterfly k of stage s: returns {addr_a, addr_b, psi_addr}.
  // With lt = LOG_N-1-s and t = 1<<lt, butterfly k belongs to group
  // i = k>>lt; the upper index inserts a zero bit at position lt of k.
  function automatic logic [3*LOG_N-1:0] bf_addr(input logic [2:0] s,
                                                 input logic [KW-1:0] k);
    logic [2:0]       lt;
    logic [LOG_N-1:0] kk, t, i, j;
    lt = S_LAST - s;
    kk = {1'b0, k};
    t  = ONE_N << lt;
    i  = kk >> lt;
    j  = (i << (lt + 3'd1)) | (kk & (t - ONE_N));
    return {j, j + t, (ONE_N << s) + i};
  endfunction

  // FSM state and stage/butterfly/drain counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      s_r     <= 3'd0;
      k_r     <= {KW{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      s_r     <= s_s;
      k_r     <= k_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    state_s = state_r;
    s_s     = s_r;
    k_s     = k_r;
    cnt_s   = cnt_r;
    xfer_s  = bf_valid & bf_ready;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ISSUE;
          s_s     = 3'd0;
          k_s     = {KW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (!xfer_s) begin
          state_s = ISSUE;
        end else if (k_r != K_LAST) begin
          k_s = k_r + K_ONE;
        end else if (BF_LATENCY > 0) begin
          state_s = DRAIN;
          cnt_s   = CNT_LAT;
        end else if (s_r == S_LAST) begin
          state_s = DONE;
        end else begin
          // Zero-latency datapath: next stage starts back to back.
          s_s = s_r + 3'd1;
          k_s = {KW{1'b0}};
        end
      end
      DRAIN: begin
        if (cnt_r > CNT_ONE) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if (s_r == S_LAST) begin
          state_s = DONE;
        end else begin
          state_s = ISSUE;
          s_s     = s_r + 3'd1;
          k_s     = {KW{1'b0}};
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    addr_vec_s = bf_addr(s_s, k_s);
  end

  // Registered outputs; addresses and stage read zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      bf_valid <= 1'b0;
      addr_a   <= {LOG_N{1'b0}};
      addr_b   <= {LOG_N{1'b0}};
      psi_addr <= {LOG_N{1'b0}};
      stage    <= 3'd0;
    end else begin
      busy     <= (state_s != IDLE);
      done     <= (state_s == DONE);
      bf_valid <= (state_s == ISSUE);
      if (state_s == IDLE) begin
        addr_a   <= {LOG_N{1'b0}};
        addr_b   <= {LOG_N{1'b0}};
        psi_addr <= {LOG_N{1'b0}};
        stage    <= 3'd0;
      end else begin
        addr_a   <= addr_vec_s[3*LOG_N-1:2*LOG_N];
        addr_b   <= addr_vec_s[2*LOG_N-1:LOG_N];
        psi_addr <= addr_vec_s[LOG_N-1:0];
        stage    <= s_s;
      end
    end
  end

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed testbench for ntt_ctrl: reset/abort, full sweep with expected
// butterfly order, backpressure, drain length, start handling, and a
// zero-latency build.
module tb_ntt_ctrl;

  localparam int LAT = 3;

  logic       clk;
  logic       rst_n;
  logic       start, start0;
  logic       bf_ready, bf_ready0;
  logic       busy, done, bf_valid;
  logic       busy0, done0, bf_valid0;
  logic [4:0] addr_a, addr_b, psi_addr;
  logic [4:0] addr_a0, addr_b0, psi_addr0;
  logic [2:0] stage, stage0;

  int n_cmp = 0;
  int n_err = 0;

  int exp_a [80];
  int exp_b [80];
  int exp_p [80];
  int exp_s [80];
  int cap_a [80];
  int cap_b [80];
  int cap_p [80];

  ntt_ctrl #(.LOG_N(5), .BF_LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .addr_a(addr_a),
    .addr_b(addr_b), .psi_addr(psi_addr), .stage(stage)
  );

  ntt_ctrl #(.LOG_N(5), .BF_LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .bf_valid(bf_valid0), .bf_ready(bf_ready0), .addr_a(addr_a0),
    .addr_b(addr_b0), .psi_addr(psi_addr0), .stage(stage0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one transform on u_dut; first valid cycle is c = 0.
  task automatic run_xfer(input bit do_start, input bit rnd, input bit inject);
    int c, idx, gap;
    logic [31:0] mask;
    bit fin, rdy;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("first_valid", bf_valid, 1);
    check("busy_on", busy, 1);
    c = 0; idx = 0; gap = 0; mask = 32'd0; fin = 1'b0;
    while (!fin && c < 2000) begin
      start = 1'b0;
      if (done) begin
        if (!rnd) check("done_at", c, (16 + LAT) * 5);
        check("xfer_total", idx, 80);
        check("last_drain", gap, LAT);
        fin = 1'b1;
        if (inject) start = 1'b1;
      end else if (bf_valid) begin
        if (gap != 0) check("drain_len", gap, LAT);
        gap = 0;
        if (idx < 80) begin
          check("addr_a", addr_a, exp_a[idx]);
          check("addr_b", addr_b, exp_b[idx]);
          check("psi_addr", psi_addr, exp_p[idx]);
          check("stage", stage, exp_s[idx]);
        end else begin
          check("extra_issue", idx, 79);
        end
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bf_ready = rdy;
        if (rdy && idx < 80) begin
          cap_a[idx] = addr_a;
          cap_b[idx] = addr_b;
          cap_p[idx] = psi_addr;
          mask = mask | (32'd1 << addr_a) | (32'd1 << addr_b);
          idx++;
          if (idx % 16 == 0) begin
            check("stage_cover", mask, 32'hFFFF_FFFF);
            mask = 32'd0;
          end
        end
      end else begin
        check("busy_in_run", busy, 1);
        gap++;
        bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (inject && (c == 5 || c == 17)) start = 1'b1;
      if (!fin) begin
        tick();
        c++;
      end
    end
    if (!fin) check("done_timeout", 0, 1);
    bf_ready = 1'b1;
  endtask

  initial begin
    int idx, c, lowcnt;
    bit fin;

    // Expected issue order: stage s has 1<<s groups of span 2t, t = 16>>s.
    idx = 0;
    for (int s = 0; s < 5; s++) begin
      for (int g = 0; g < (1 << s); g++) begin
        for (int off = 0; off < (16 >> s); off++) begin
          exp_a[idx] = g * 2 * (16 >> s) + off;
          exp_b[idx] = exp_a[idx] + (16 >> s);
          exp_p[idx] = (1 << s) + g;
          exp_s[idx] = s;
          idx++;
        end
      end
    end

    rst_n = 1'b0; start = 1'b0; start0 = 1'b0;
    bf_ready = 1'b1; bf_ready0 = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bf_valid, 0);
    check("rst_addr_a", addr_a, 0);
    check("rst_addr_b", addr_b, 0);
    check("rst_psi", psi_addr, 0);
    check("rst_stage", stage, 0);
    rst_n = 1'b1;
    tick();

    // Abort mid-ISSUE with an asynchronous reset.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abort_pre_valid", bf_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", bf_valid, 0);
    check("abort_done", done, 0);
    check("abort_addr_a", addr_a, 0);
    check("abort_addr_b", addr_b, 0);
    check("abort_psi", psi_addr, 0);
    check("abort_stage", stage, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("abort_idle", busy, 0);
    check("abort_no_done", done, 0);

    // Full sweep, ready high, with start pulses in ISSUE, DRAIN and DONE.
    run_xfer(1'b1, 1'b0, 1'b1);
    check("vec0_a", cap_a[0], 0);  check("vec0_b", cap_b[0], 16); check("vec0_p", cap_p[0], 1);
    check("vec1_a", cap_a[1], 1);  check("vec1_b", cap_b[1], 17); check("vec1_p", cap_p[1], 1);
    check("vec2_a", cap_a[2], 2);  check("vec2_b", cap_b[2], 18); check("vec2_p", cap_p[2], 1);
    check("vec24_a", cap_a[24], 16); check("vec24_b", cap_b[24], 24); check("vec24_p", cap_p[24], 3);
    check("vec79_a", cap_a[79], 30); check("vec79_b", cap_b[79], 31); check("vec79_p", cap_p[79], 31);
    tick();
    start = 1'b0;
    check("done_pulse", done, 0);
    check("start_in_done_ignored", busy, 0);

    // Start in the IDLE cycle after DONE, then a backpressured run.
    start = 1'b1;
    tick();
    start = 1'b0;
    run_xfer(1'b0, 1'b1, 1'b0);
    tick();
    check("idle_after_rnd", busy, 0);
    check("done_pulse_rnd", done, 0);

    // Zero-latency build: stages back to back.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("lat0_first_valid", bf_valid0, 1);
    c = 0; idx = 0; lowcnt = 0; fin = 1'b0;
    while (!fin && c < 500) begin
      if (done0) begin
        check("lat0_done_at", c, 80);
        check("lat0_xfers", idx, 80);
        check("lat0_gaps", lowcnt, 0);
        fin = 1'b1;
      end else if (bf_valid0) begin
        if (idx < 80) begin
          check("lat0_addr_a", addr_a0, exp_a[idx]);
          check("lat0_addr_b", addr_b0, exp_b[idx]);
          check("lat0_psi", psi_addr0, exp_p[idx]);
        end else begin
          check("lat0_extra", idx, 79);
        end
        idx++;
      end else begin
        lowcnt++;
      end
      if (!fin) begin
        tick();
        c++;
      end
    end
    if (!fin) check("lat0_timeout", 0, 1);
    tick();
    check("lat0_idle", busy0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
